// File: rtl/ase_pkg.sv
// Shared ASE types for the UMsg delivery path: channel-0 UMsg header layout,
// slot state encoding and the default hint/data delays.
package ase_pkg;

  localparam int         NUM_UMSG_PER_AFU        = 8;
  localparam int         UMSG_HINT_DELAY_DEFAULT = 16;
  localparam int         UMSG_DATA_DELAY_DEFAULT = 32;
  localparam logic [3:0] ASE_UMSG                = 4'h6;

  typedef enum logic [2:0] {
    UMsgIdle     = 3'd0,
    UMsgHintWait = 3'd1,
    UMsgSendHint = 3'd2,
    UMsgDataWait = 3'd3,
    UMsgSendData = 3'd4
  } UMsg_StateEnum;

  typedef struct packed {
    logic [2:0] rsvd_27_25;
    logic       poison;
    logic [3:0] resp_type;
    logic [4:0] rsvd_19_15;
    logic       umsg_type;
    logic [7:0] rsvd_13_6;
    logic [5:0] umsg_id;
  } UMsgHdr_t;

  // Per-slot record at the default 8-bit timer width.
  typedef struct packed {
    UMsg_StateEnum state;
    logic [7:0]    hint_timer;
    logic [7:0]    data_timer;
    logic [511:0]  data;
  } umsg_t;

  function automatic UMsgHdr_t umsg_hdr(input logic hint, input logic [5:0] id);
    UMsgHdr_t h;
    h           = '0;
    h.resp_type = ASE_UMSG;
    h.umsg_type = hint;
    h.umsg_id   = id;
    return h;
  endfunction

endpackage

// File: rtl/ase_umsg_ctrl_if.sv
// UMsg command intake and RX channel-0 response bundle.
interface ase_umsg_ctrl_if
  import ase_pkg::*;
#(
  parameter int NUM_UMSG = NUM_UMSG_PER_AFU
);
  localparam int IDW = $clog2(NUM_UMSG);

  logic           cmd_valid;
  logic [IDW-1:0] cmd_id;
  logic [511:0]   cmd_data;
  logic           cmd_ready;
  logic           rx0_valid;
  UMsgHdr_t       rx0_hdr;
  logic [511:0]   rx0_data;
  logic           rx0_ready;

  modport slave (
    input  cmd_valid, cmd_id, cmd_data, rx0_ready,
    output cmd_ready, rx0_valid, rx0_hdr, rx0_data
  );

  modport master (
    output cmd_valid, cmd_id, cmd_data, rx0_ready,
    input  cmd_ready, rx0_valid, rx0_hdr, rx0_data
  );

endinterface

// File: rtl/ase_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a pointer that
// moves to the slot after each winner. N must be a power of 2.
module ase_rr_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    idx   = '0;
    found = 1'b0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        idx = ptr_q + PW'(i);
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          ptr_d    = idx + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ase_umsg_ctrl.sv
// UMsg delivery engine: per-slot hint/data FSMs whose send requests are
// round-robin arbitrated into a single RX channel-0 response register.
module ase_umsg_ctrl
  import ase_pkg::*;
#(
  parameter int NUM_UMSG    = NUM_UMSG_PER_AFU,
  parameter int TIMER_WIDTH = 8,
  parameter int HINT_DELAY  = UMSG_HINT_DELAY_DEFAULT,
  parameter int DATA_DELAY  = UMSG_DATA_DELAY_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_UMSG-1:0] hint_en,
  ase_umsg_ctrl_if.slave      bus,
  output logic [NUM_UMSG-1:0] slot_busy
);
  localparam int                     IDW       = $clog2(NUM_UMSG);
  localparam logic [TIMER_WIDTH-1:0] HINT_LOAD = TIMER_WIDTH'(HINT_DELAY);
  localparam logic [TIMER_WIDTH-1:0] DATA_LOAD = TIMER_WIDTH'(DATA_DELAY);
  localparam logic [TIMER_WIDTH-1:0] TMR_ONE   = TIMER_WIDTH'(1);

  logic [NUM_UMSG-1:0] slot_idle, send_req, send_hint, gnt;
  logic [511:0]        slot_data [NUM_UMSG];
  logic                arb_en;
  logic [IDW-1:0]      win_idx;
  logic                win_hint;
  logic                rx0_valid_q;
  UMsgHdr_t            rx0_hdr_q;
  logic [511:0]        rx0_data_q;

  assign bus.cmd_ready = slot_idle[bus.cmd_id];
  assign slot_busy     = ~slot_idle;
  assign arb_en        = !rx0_valid_q || bus.rx0_ready;

  for (genvar g = 0; g < NUM_UMSG; g++) begin : gen_slot
    UMsg_StateEnum          state_q, state_d;
    logic [TIMER_WIDTH-1:0] hint_timer_q, hint_timer_d;
    logic [TIMER_WIDTH-1:0] data_timer_q, data_timer_d;
    logic                   gap_q, gap_d;
    logic [511:0]           data_q;
    logic                   accept;

    assign accept = bus.cmd_valid && (bus.cmd_id == IDW'(g)) && (state_q == UMsgIdle);

    always_comb begin
      state_d      = state_q;
      hint_timer_d = hint_timer_q;
      data_timer_d = data_timer_q;
      gap_d        = gap_q;
      case (state_q)
        UMsgIdle: begin
          if (accept) begin
            if (hint_en[g]) begin
              state_d      = UMsgHintWait;
              hint_timer_d = HINT_LOAD;
            end else begin
              state_d      = UMsgDataWait;
              data_timer_d = DATA_LOAD;
              gap_d        = 1'b0;
            end
          end
        end
        UMsgHintWait: begin
          if (hint_timer_q == '0) state_d = UMsgSendHint;
          else                    hint_timer_d = hint_timer_q - TMR_ONE;
        end
        UMsgSendHint: begin
          if (gnt[g]) begin
            state_d      = UMsgDataWait;
            data_timer_d = DATA_LOAD;
            gap_d        = 1'b1;
          end
        end
        UMsgDataWait: begin
          // After a hint the data countdown starts one cycle late.
          if (gap_q)                   gap_d = 1'b0;
          else if (data_timer_q == '0) state_d = UMsgSendData;
          else                         data_timer_d = data_timer_q - TMR_ONE;
        end
        UMsgSendData: begin
          if (gnt[g]) state_d = UMsgIdle;
        end
        default: state_d = UMsgIdle;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q      <= UMsgIdle;
        hint_timer_q <= '0;
        data_timer_q <= '0;
        gap_q        <= 1'b0;
      end else begin
        state_q      <= state_d;
        hint_timer_q <= hint_timer_d;
        data_timer_q <= data_timer_d;
        gap_q        <= gap_d;
      end
    end

    always_ff @(posedge clk) begin
      if (accept) data_q <= bus.cmd_data;
    end

    assign slot_idle[g] = (state_q == UMsgIdle);
    assign send_hint[g] = (state_q == UMsgSendHint);
    assign send_req[g]  = (state_q == UMsgSendHint) || (state_q == UMsgSendData);
    assign slot_data[g] = data_q;
  end

  ase_rr_arbiter #(.N(NUM_UMSG)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (send_req),
    .en  (arb_en),
    .gnt (gnt)
  );

  always_comb begin
    win_idx  = '0;
    win_hint = 1'b0;
    for (int i = 0; i < NUM_UMSG; i++) begin
      if (gnt[i]) begin
        win_idx  = IDW'(i);
        win_hint = send_hint[i];
      end
    end
  end

  // Response register: loads on grant, holds while the mux stalls it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx0_valid_q <= 1'b0;
      rx0_hdr_q   <= '0;
      rx0_data_q  <= '0;
    end else if (arb_en) begin
      rx0_valid_q <= |gnt;
      if (|gnt) begin
        rx0_hdr_q  <= umsg_hdr(win_hint, 6'(win_idx));
        rx0_data_q <= win_hint ? '0 : slot_data[win_idx];
      end
    end
  end

  assign bus.rx0_valid = rx0_valid_q;
  assign bus.rx0_hdr   = rx0_hdr_q;
  assign bus.rx0_data  = rx0_data_q;

endmodule

// File: tb/tb_ase_umsg_ctrl.sv
// Directed bench for ase_umsg_ctrl: a cycle-stamped delivery model is checked
// against the DUT every cycle, plus hand-computed latency/order expectations.
`timescale 1ns/1ps
module tb_ase_umsg_ctrl;
  import ase_pkg::*;

  localparam int N  = 8;
  localparam int HD = 2;
  localparam int DD = 4;

  typedef struct {
    int           c;
    int           id;
    logic [511:0] d;
  } resp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] hint_en = '0;
  logic [N-1:0] slot_busy;
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  bit           chk_en = 1'b0;
  resp_t        r_q[$];

  // Model: phase 0 idle, 1 hint owed, 2 data owed; due = first cycle eligible to send.
  int           m_phase [N];
  int           m_due   [N];
  logic [511:0] m_pay   [N];
  int           m_ptr = 0;
  logic         m_valid = 1'b0;
  UMsgHdr_t     m_hdr = '0;
  logic [511:0] m_dout = '0;

  ase_umsg_ctrl_if #(.NUM_UMSG(N)) bus ();

  ase_umsg_ctrl #(
    .NUM_UMSG(N), .TIMER_WIDTH(8), .HINT_DELAY(HD), .DATA_DELAY(DD)
  ) dut (
    .clk(clk), .rst(rst), .hint_en(hint_en), .bus(bus), .slot_busy(slot_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int win;
    bit acc;
    if (rst) begin
      for (int s = 0; s < N; s++) m_phase[s] = 0;
      m_ptr = 0; m_valid = 1'b0; m_hdr = '0; m_dout = '0;
    end else begin
      acc = bus.cmd_valid && (m_phase[bus.cmd_id] == 0);
      win = -1;
      if (!m_valid || bus.rx0_ready) begin
        for (int k = 0; k < N; k++) begin
          int s;
          s = (m_ptr + k) % N;
          if (win < 0 && m_phase[s] != 0 && m_due[s] <= cyc) win = s;
        end
        m_valid = (win >= 0);
        if (win >= 0) begin
          m_hdr           = '0;
          m_hdr.resp_type = 4'h6;
          m_hdr.umsg_id   = 6'(win);
          m_hdr.umsg_type = (m_phase[win] == 1);
          m_dout          = (m_phase[win] == 1) ? '0 : m_pay[win];
          if (m_phase[win] == 1) begin
            m_phase[win] = 2;
            m_due[win]   = cyc + DD + 3;
          end else begin
            m_phase[win] = 0;
          end
          m_ptr = (win + 1) % N;
        end
      end
      if (acc) begin
        m_pay[bus.cmd_id] = bus.cmd_data;
        if (hint_en[bus.cmd_id]) begin
          m_phase[bus.cmd_id] = 1;
          m_due[bus.cmd_id]   = cyc + HD + 2;
        end else begin
          m_phase[bus.cmd_id] = 2;
          m_due[bus.cmd_id]   = cyc + DD + 2;
        end
      end
    end
    cyc = cyc + 1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [N-1:0] mb;
    resp_t        r;
    @(negedge clk);
    if (chk_en) begin
      for (int s = 0; s < N; s++) mb[s] = (m_phase[s] != 0);
      chk("rx0_valid", 512'(bus.rx0_valid), 512'(m_valid));
      if (m_valid) begin
        chk("rx0_hdr", 512'(bus.rx0_hdr), 512'(m_hdr));
        chk("rx0_data", bus.rx0_data, m_dout);
      end
      chk("slot_busy", 512'(slot_busy), 512'(mb));
      chk("cmd_ready", 512'(bus.cmd_ready), 512'(m_phase[bus.cmd_id] == 0));
      if (bus.rx0_valid && bus.rx0_ready) begin
        r.c = cyc; r.id = int'(bus.rx0_hdr.umsg_id); r.d = bus.rx0_data;
        r_q.push_back(r);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int id, input logic [511:0] d, output int t_acc);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_id    = 3'(id);
    bus.cmd_data  = d;
    #1;
    while (!bus.cmd_ready && n < 100) begin
      tick();
      n++;
    end
    chk("issue_timeout", 512'(n >= 100), 512'(0));
    t_acc = cyc;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output int t);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rx0_valid && n < maxc);
    chk("wait_valid_timeout", 512'(bus.rx0_valid), 512'(1));
    t = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int           t, tv, th, td, ta, tb;
    int           exp_id [3];
    logic [511:0] exp_pl [3];
    logic [511:0] pa5, p2, p0, p1, p7, x1, x2, y4, y6;

    bus.cmd_valid = 1'b0; bus.cmd_id = '0; bus.cmd_data = '0; bus.rx0_ready = 1'b1;
    pa5 = {16{32'hA5A5A5A5}};
    p2  = {8{64'h0123456789ABCDEF}};
    p0  = {64{8'h10}}; p1 = {64{8'h21}}; p7 = {64{8'h7E}};
    x1  = {16{32'hDEADBEEF}}; x2 = {16{32'h5A5A0F0F}};
    y4  = {16{32'h44444444}}; y6 = {16{32'h66666666}};

    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset state
    chk("rst_valid", 512'(bus.rx0_valid), 512'(0));
    chk("rst_hdr", 512'(bus.rx0_hdr), '0);
    chk("rst_data", bus.rx0_data, '0);
    chk("rst_busy", 512'(slot_busy), '0);
    for (int i = 0; i < N; i++) begin
      bus.cmd_id = 3'(i);
      #1;
      chk("rst_ready", 512'(bus.cmd_ready), 512'(1));
    end
    tick();

    // No-hint single slot
    issue(3, pa5, t);
    chk("busy_rise", 512'(slot_busy), 512'(8'h08));
    wait_valid(40, tv);
    chk("nohint_lat", 512'(tv), 512'(t + 7));
    chk("nohint_type", 512'(bus.rx0_hdr.umsg_type), 512'(0));
    chk("nohint_id", 512'(bus.rx0_hdr.umsg_id), 512'(3));
    chk("nohint_resp", 512'(bus.rx0_hdr.resp_type), 512'(6));
    chk("nohint_data", bus.rx0_data, pa5);
    chk("busy_fall", 512'(slot_busy), 512'(0));
    @(negedge clk);
    chk("one_cycle", 512'(bus.rx0_valid), 512'(0));

    // Hint path
    tick();
    hint_en = 8'h04;
    issue(2, p2, t);
    wait_valid(40, th);
    chk("hint_lat", 512'(th), 512'(t + 5));
    chk("hint_type", 512'(bus.rx0_hdr.umsg_type), 512'(1));
    chk("hint_id", 512'(bus.rx0_hdr.umsg_id), 512'(2));
    chk("hint_zero", bus.rx0_data, '0);
    wait_valid(40, td);
    chk("hdata_lat", 512'(td), 512'(t + 12));
    chk("hdata_type", 512'(bus.rx0_hdr.umsg_type), 512'(0));
    chk("hdata_data", bus.rx0_data, p2);

    // Arbitration under backpressure
    tick();
    hint_en       = '0;
    bus.rx0_ready = 1'b0;
    issue(0, p0, t);
    issue(1, p1, tv);
    issue(7, p7, th);
    chk("b2b_accept", 512'(th), 512'(t + 2));
    wait_valid(40, tv);
    chk("bp_first", 512'(tv), 512'(t + 7));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 512'(bus.rx0_valid), 512'(1));
      chk("bp_hold_id", 512'(bus.rx0_hdr.umsg_id), 512'(0));
      chk("bp_hold_data", bus.rx0_data, p0);
    end
    tick();
    bus.rx0_ready = 1'b1;
    exp_id = '{0, 1, 7};
    exp_pl = '{p0, p1, p7};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rr_valid", 512'(bus.rx0_valid), 512'(1));
      chk("rr_id", 512'(bus.rx0_hdr.umsg_id), 512'(exp_id[k]));
      chk("rr_data", bus.rx0_data, exp_pl[k]);
    end
    @(negedge clk);
    chk("rr_drained", 512'(bus.rx0_valid), 512'(0));

    // Second command to a busy slot
    tick();
    r_q.delete();
    issue(5, x1, ta);
    issue(5, x2, tb);
    chk("busy_accept", 512'(tb), 512'(ta + 7));
    repeat (12) tick();
    chk("busy_count", 512'(r_q.size()), 512'(2));
    if (r_q.size() >= 2) begin
      chk("busy_first_cyc", 512'(r_q[0].c), 512'(ta + 7));
      chk("busy_first_data", r_q[0].d, x1);
      chk("busy_second_cyc", 512'(r_q[1].c), 512'(tb + 7));
      chk("busy_second_data", r_q[1].d, x2);
    end

    // Reset mid-operation
    bus.rx0_ready = 1'b0;
    hint_en       = 8'h10;
    issue(6, y6, t);
    wait_valid(40, tv);
    chk("mid_held_lat", 512'(tv), 512'(t + 7));
    tick();
    issue(4, y4, ta);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 512'(bus.rx0_valid), 512'(0));
    chk("mid_rst_busy", 512'(slot_busy), 512'(0));
    bus.rx0_ready = 1'b1;
    r_q.delete();
    repeat (40) tick();
    chk("no_stale", 512'(r_q.size()), 512'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
